branch_controller: RTL

Decode-stage sequencer wrapped around the jump unit. It stalls branch/jump instructions until their operands are forwardable and arbitrates the $ra link write through a req/ack handshake. It then issues a one-cycle PC redirect with an IF flush. It sits between decode, the hazard/forwarding logic, the PC register and the register-file write-port arbiter.

---
 rtl/branch_controller_pkg.sv | 22 ++
 rtl/branch_hazard_detect.sv | 45 ++++
 rtl/branch_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/branch_controller_pkg.sv
// Shared encodings for the decode-stage branch sequencer: FSM states,
// the hardwired-zero register number and hazard wait counts.
package branch_controller_pkg;

  typedef enum logic [1:0] {
    BC_IDLE     = 2'd0,
    BC_WAIT     = 2'd1,
    BC_LINK     = 2'd2,
    BC_REDIRECT = 2'd3
  } bc_state_e;

  localparam int REG_ZERO = 0;

  localparam logic [1:0] HAZ_NONE = 2'd0;
  localparam logic [1:0] HAZ_ALU  = 2'd1;
  localparam logic [1:0] HAZ_LOAD = 2'd2;

  function automatic logic [1:0] haz_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational count of cycles a branch must wait before both compare
// operands can be forwarded into decode.
module branch_hazard_detect
  import branch_controller_pkg::*;
#(
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic [REG_NUM_WIDTH-1:0] rs_num,
  input  logic [REG_NUM_WIDTH-1:0] rt_num,
  input  logic                     uses_rt,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_to_reg,
  input  logic [REG_NUM_WIDTH-1:0] ex_write_num,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_to_reg,
  input  logic [REG_NUM_WIDTH-1:0] mem_write_num,
  output logic [1:0]               h
);

  logic [REG_NUM_WIDTH-1:0] src_num [2];
  logic [1:0]               src_used;
  logic [1:0]               src_h [2];

  assign src_num[0] = rs_num;
  assign src_num[1] = rt_num;
  assign src_used   = {uses_rt, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      always_comb begin
        src_h[gi] = HAZ_NONE;
        if (src_used[gi] && src_num[gi] != REG_NUM_WIDTH'(REG_ZERO)) begin
          if (ex_reg_write && src_num[gi] == ex_write_num)
            src_h[gi] = ex_mem_to_reg ? HAZ_LOAD : HAZ_ALU;
          // An ALU result in MEM is already forwardable; only a load still blocks.
          else if (mem_reg_write && mem_mem_to_reg && src_num[gi] == mem_write_num)
            src_h[gi] = HAZ_ALU;
        end
      end
    end
  endgenerate

  assign h = haz_max(src_h[0], src_h[1]);

endmodule

// File: rtl/branch_controller.sv
// Decode-stage branch sequencer: hazard stall, $ra link handshake, PC redirect.
// Optional BRANCH_STATS_EN adds saturating taken/stall-cycle counters.
module branch_controller
  import branch_controller_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
`ifdef BRANCH_STATS_EN
  , parameter int STAT_WIDTH  = 16
`endif
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic                     id_branch,
  input  logic [REG_NUM_WIDTH-1:0] id_rs_num,
  input  logic [REG_NUM_WIDTH-1:0] id_rt_num,
  input  logic                     id_uses_rt,
  input  logic                     ex_reg_write,
  input  logic                     ex_mem_to_reg,
  input  logic [REG_NUM_WIDTH-1:0] ex_write_num,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_to_reg,
  input  logic [REG_NUM_WIDTH-1:0] mem_write_num,
  input  logic                     ju_pc_src,
  input  logic [ADDR_WIDTH-1:0]    ju_jump_address,
  input  logic                     ju_ra_write,
  input  logic [ADDR_WIDTH-1:0]    ju_ra_value,
  input  logic                     ra_ack,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     flush_if,
  output logic                     pc_load,
  output logic [ADDR_WIDTH-1:0]    pc_target,
  output logic                     ra_req,
  output logic [ADDR_WIDTH-1:0]    ra_data,
  output logic                     busy
`ifdef BRANCH_STATS_EN
  , output logic [STAT_WIDTH-1:0]  stat_taken
  , output logic [STAT_WIDTH-1:0]  stat_stall_cycles
`endif
);

  bc_state_e             state_reg, state_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic                  pc_load_reg, pc_load_next;
  logic                  ra_req_reg, ra_req_next;
  logic [ADDR_WIDTH-1:0] pc_target_reg, pc_target_next;
  logic [ADDR_WIDTH-1:0] ra_data_reg, ra_data_next;
  logic                  stall;
  logic [1:0]            h;

  branch_hazard_detect #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_hazard (
    .rs_num         (id_rs_num),
    .rt_num         (id_rt_num),
    .uses_rt        (id_uses_rt),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_write_num   (ex_write_num),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_write_num  (mem_write_num),
    .h              (h)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= BC_IDLE;
      cnt_reg       <= '0;
      pc_load_reg   <= 1'b0;
      ra_req_reg    <= 1'b0;
      pc_target_reg <= '0;
      ra_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pc_load_reg   <= pc_load_next;
      ra_req_reg    <= ra_req_next;
      pc_target_reg <= pc_target_next;
      ra_data_reg   <= ra_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pc_load_next   = 1'b0;
    ra_req_next    = ra_req_reg;
    pc_target_next = pc_target_reg;
    ra_data_next   = ra_data_reg;
    stall          = 1'b0;
    unique case (state_reg)
      BC_IDLE: begin
        if (id_valid && id_branch) begin
          if (h != HAZ_NONE) begin
            stall      = 1'b1;
            cnt_next   = h;
            state_next = BC_WAIT;
          end else if (ju_pc_src) begin
            stall          = 1'b1;
            pc_target_next = ju_jump_address;
            if (ju_ra_write) begin
              ra_data_next = ju_ra_value;
              ra_req_next  = 1'b1;
              state_next   = BC_LINK;
            end else begin
              pc_load_next = 1'b1;
              state_next   = BC_REDIRECT;
            end
          end
        end
      end
      BC_WAIT: begin
        stall    = 1'b1;
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1)
          state_next = BC_IDLE;
      end
      BC_LINK: begin
        stall = 1'b1;
        if (ra_ack) begin
          ra_req_next  = 1'b0;
          pc_load_next = 1'b1;
          state_next   = BC_REDIRECT;
        end
      end
      BC_REDIRECT: state_next = BC_IDLE;
      default:     state_next = BC_IDLE;
    endcase
  end

  // pc_load and flush_if are high exactly while the FSM sits in REDIRECT.
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign pc_load   = pc_load_reg;
  assign flush_if  = pc_load_reg;
  assign pc_target = pc_target_reg;
  assign ra_req    = ra_req_reg;
  assign ra_data   = ra_data_reg;
  assign busy      = (state_reg != BC_IDLE);

`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] stat_taken_reg, stat_stall_cycles_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_taken_reg        <= '0;
      stat_stall_cycles_reg <= '0;
    end else begin
      if (state_reg == BC_REDIRECT && stat_taken_reg != '1)
        stat_taken_reg <= stat_taken_reg + 1'b1;
      if (stall && stat_stall_cycles_reg != '1)
        stat_stall_cycles_reg <= stat_stall_cycles_reg + 1'b1;
    end
  end

  assign stat_taken        = stat_taken_reg;
  assign stat_stall_cycles = stat_stall_cycles_reg;
`endif

endmodule
